sc2bin_acc: RTL and testbench
=============================

SC2BIN_ACC -- requirements
Module: sc2bin_acc

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: binary width of the result; window length = 2^BITWIDTH enabled cycles.
REQ-002 SHALL have port iClk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port iRst  input  1: synchronous reset, active-high.
REQ-004 SHALL have port iBit  input  1: unary bitstream from the upstream multiplier stage.
REQ-005 SHALL have port iEn  input  1: iBit is valid and sampled this cycle.
REQ-006 SHALL have port iStart  input  1: request to begin a new conversion window.
REQ-007 SHALL have port iReady  input  1: downstream consumer accepts oResult.
REQ-008 SHALL have port oClr  output  1: one-cycle pulse that clears the upstream sequence generator at window start.
REQ-009 SHALL have port oBusy  output  1: high while a window is accumulating.
REQ-010 SHALL have port oValid  output  1: oResult holds a completed conversion.
REQ-011 SHALL have port oResult  output  BITWIDTH: count of ones in the last window, saturated.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-013 IDLE: on iStart=1, the block SHALL go to ACCUM next cycle, zero the window counter and ones counter, and drive oClr=1 combinationally in that same cycle.
REQ-014 IDLE without iStart SHALL stay in IDLE; oBusy=0, oValid=0.
REQ-015 ACCUM: each cycle with iEn=1, the block SHALL increment the window counter (BITWIDTH bits) and add iBit to the ones counter (BITWIDTH+1 bits); cycles with iEn=0 SHALL change no state.
REQ-016 ACCUM: when iEn=1 and the window counter equals 2^BITWIDTH-1, that sample SHALL be counted, the result captured, and the FSM SHALL enter DONE next cycle.
REQ-017 Captured oResult SHALL be min(ones, 2^BITWIDTH-1); e.g. 256 ones with BITWIDTH=8 yields 255.
REQ-018 iStart during ACCUM SHALL be ignored; oClr SHALL stay 0.
REQ-019 DONE: oValid=1 with oResult stable until iReady=1; oBusy=0.
REQ-020 DONE with iReady=1 and iStart=0 SHALL go to IDLE; oValid drops next cycle.
REQ-021 DONE with iReady=1 and iStart=1 SHALL go directly to ACCUM (back-to-back), pulse oClr that cycle and clear counters; no IDLE cycle.
REQ-022 DONE with iStart=1 and iReady=0 SHALL ignore iStart.
REQ-023 oResult SHALL retain its last captured value in IDLE and ACCUM; it is meaningful only while oValid=1.
REQ-024 Latency: oValid SHALL rise exactly one cycle after the 2^BITWIDTH-th enabled sample.
REQ-025 oBusy SHALL be 1 exactly in ACCUM.

Reset
REQ-026 iRst=1 at a rising edge SHALL force IDLE, clear all counters, and set oResult=0, oValid=0, oBusy=0; it overrides all other inputs.
REQ-027 oClr SHALL be 0 while iRst=1.
REQ-028 Reset mid-ACCUM or mid-DONE SHALL discard the partial or pending result; no oValid afterwards until a new full window completes.

Verification
REQ-029 BITWIDTH=8; iStart pulse, iEn=1, iBit=1 for 256 cycles -> oClr pulse on the start cycle, oValid rises 1 cycle after the 256th sample, oResult=255 (saturated).
REQ-030 iBit alternating 1,0 with iEn=1 for 256 cycles -> oResult=128; an all-zero stream -> oResult=0.
REQ-031 iEn low every other cycle, iBit=1 -> window spans 512 cycles, oResult=255; samples taken while iEn=0 are not counted.
REQ-032 iReady held 0 for 10 cycles in DONE, iStart pulsed meanwhile -> oValid and oResult held stable, iStart ignored; iReady=1 -> IDLE next cycle.
REQ-033 In DONE, iReady=1 and iStart=1 together -> oClr=1 that cycle, ACCUM next cycle, second window result correct and independent of the first.
REQ-034 iRst=1 after 100 ACCUM samples -> IDLE with outputs 0; the following full window yields the correct count with no residue from the aborted window.

Source files
------------

// File: rtl/sc2bin_acc.sv
// Stochastic-to-binary accumulator: counts ones over a 2^BITWIDTH-sample window of a
// unary bitstream and hands the saturated count to a ready/valid consumer.
module sc2bin_acc #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iBit,
  input  logic                iEn,
  input  logic                iStart,
  input  logic                iReady,
  output logic                oClr,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oResult
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [BITWIDTH:0]   ones_q, ones_d;
  logic [BITWIDTH-1:0] result_q, result_d;
  logic                clr;
  logic [BITWIDTH:0]   ones_inc;

  assign ones_inc = ones_q + {{BITWIDTH{1'b0}}, iBit};

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    ones_d    = ones_q;
    result_d  = result_q;
    clr       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          clr       = 1'b1;
          state_d   = StAccum;
          win_cnt_d = '0;
          ones_d    = '0;
        end
      end
      StAccum: begin
        if (iEn) begin
          win_cnt_d = win_cnt_q + 1'b1;
          ones_d    = ones_inc;
          if (win_cnt_q == {BITWIDTH{1'b1}}) begin
            // A full window of ones overflows the result width; clamp to all-ones.
            result_d = ones_inc[BITWIDTH] ? {BITWIDTH{1'b1}} : ones_inc[BITWIDTH-1:0];
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        if (iReady) begin
          if (iStart) begin
            clr       = 1'b1;
            state_d   = StAccum;
            win_cnt_d = '0;
            ones_d    = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= StIdle;
      win_cnt_q <= '0;
      ones_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      ones_q    <= ones_d;
      result_q  <= result_d;
    end
  end

  assign oClr    = clr & ~iRst;
  assign oBusy   = (state_q == StAccum);
  assign oValid  = (state_q == StDone);
  assign oResult = result_q;

endmodule

// File: tb/tb_sc2bin_acc.sv
// Randomized self-checking bench for sc2bin_acc; expected counts come from summing the
// enabled samples the bench itself generated.
module tb_sc2bin_acc;
  localparam int unsigned BW  = 8;
  localparam int          WIN = 1 << BW;

  logic          clk = 1'b0;
  logic          rst, bit_in, en, start, ready;
  logic          clr, busy, valid;
  logic [BW-1:0] result;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  sc2bin_acc #(.BITWIDTH(BW)) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iBit   (bit_in),
    .iEn    (en),
    .iStart (start),
    .iReady (ready),
    .oClr   (clr),
    .oBusy  (busy),
    .oValid (valid),
    .oResult(result)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic gen_bit(input int pat, input int idx);
    case (pat)
      0:       return 1'b1;
      1:       return (idx % 2) == 0;
      2:       return 1'b0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic gen_en(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; en = 1'b1; bit_in = 1'b1; ready = 1'b1;
    #1 check_eq("clr_in_reset", 32'(clr), 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; en = 1'b0; ready = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_result", 32'(result), 0);
    check_eq("rst_clr", 32'(clr), 0);
  endtask

  // Starts a window (from IDLE, or from DONE when from_done is set) and feeds stop_after
  // enabled samples; a full window is then checked for a one-cycle valid latency.
  task automatic run_window(input int pat, input int en_mode, input bit from_done,
                            input int stop_after, output int exp_res);
    int ones  = 0;
    int taken = 0;
    int cyc   = 0;
    @(negedge clk);
    start = 1'b1; ready = from_done; en = 1'($urandom_range(0, 1)); bit_in = 1'b1;
    #1 check_eq("clr_start", 32'(clr), 1);
    while (taken < stop_after) begin
      @(negedge clk);
      start  = 1'($urandom_range(0, 1));
      ready  = 1'($urandom_range(0, 1));
      en     = gen_en(en_mode, cyc);
      bit_in = en ? gen_bit(pat, taken) : 1'($urandom_range(0, 1));
      #1;
      check_eq("accum_busy", 32'(busy), 1);
      check_eq("accum_valid", 32'(valid), 0);
      check_eq("accum_clr", 32'(clr), 0);
      if (en) begin
        ones += int'(bit_in);
        taken++;
      end
      cyc++;
    end
    exp_res = (ones > WIN - 1) ? WIN - 1 : ones;
    if (stop_after == WIN) begin
      @(negedge clk);
      start = 1'b0; ready = 1'b0; en = 1'b1; bit_in = 1'b1;
      #1;
      check_eq("done_valid", 32'(valid), 1);
      check_eq("done_busy", 32'(busy), 0);
      check_eq("done_result", 32'(result), 32'(exp_res));
    end
  endtask

  task automatic hold_done(input int n, input int exp_res);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ready = 1'b0; start = 1'($urandom_range(0, 1)); en = 1'($urandom_range(0, 1));
      #1;
      check_eq("hold_valid", 32'(valid), 1);
      check_eq("hold_result", 32'(result), 32'(exp_res));
      check_eq("hold_clr", 32'(clr), 0);
      check_eq("hold_busy", 32'(busy), 0);
    end
  endtask

  task automatic release_to_idle(input int exp_res);
    @(negedge clk);
    ready = 1'b1; start = 1'b0;
    #1 check_eq("release_clr", 32'(clr), 0);
    @(negedge clk);
    ready = 1'b0;
    #1;
    check_eq("idle_valid", 32'(valid), 0);
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_result_kept", 32'(result), 32'(exp_res));
  endtask

  initial begin
    int  r;
    bit  in_done;
    rst = 1'b0; bit_in = 1'b0; en = 1'b0; start = 1'b0; ready = 1'b0;
    do_reset();

    run_window(0, 0, 1'b0, WIN, r);   // saturating all-ones window
    hold_done(10, r);
    release_to_idle(r);

    run_window(1, 0, 1'b0, WIN, r);   // alternating -> 128
    release_to_idle(r);

    run_window(2, 0, 1'b0, WIN, r);   // all zero
    run_window(0, 1, 1'b1, WIN, r);   // back-to-back, half-rate enable
    release_to_idle(r);

    run_window(3, 2, 1'b0, 100, r);   // aborted by reset
    do_reset();
    run_window(1, 0, 1'b0, WIN, r);

    do_reset();                        // discard pending result in DONE
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ready = 1'($urandom_range(0, 1)); en = 1'b1;
      #1 check_eq("post_rst_valid", 32'(valid), 0);
    end

    in_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bit b2b;
      b2b = in_done && ($urandom_range(0, 1) == 1);
      if (in_done && !b2b) release_to_idle(r);
      run_window(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), b2b, WIN, r);
      hold_done(int'($urandom_range(0, 5)), r);
      in_done = 1'b1;
    end
    release_to_idle(r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
